// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin share of one MAC between two requesters; define MAC_ARB_FIXED_PRIO_EN for fixed priority to requester 0
module mac_arbiter #(
  parameter int W       = 256,
  parameter int LATENCY = 133
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [2*W-1:0] rsp_data,
  output logic [W-1:0]   mac_a,
  output logic [W-1:0]   mac_b,
  output logic           mac_rst_n,
  output logic           mac_en,
  input  logic [2*W-1:0] mac_out,
  output logic           busy,
  output logic           owner
);
  localparam int CW = $clog2(LATENCY);
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic ptr;
  logic idle;
  logic g1;
  logic rsp_hs;
  always_comb begin
    idle       = state == IDLE && !rst;
    g1         = req1_valid && (ptr || !req0_valid);
    req0_ready = idle && req0_valid && !g1;
    req1_ready = idle && g1;
    busy       = state != IDLE;
    rsp0_valid = state == DONE && !owner;
    rsp1_valid = state == DONE && owner;
    rsp_hs     = owner ? rsp1_ready : rsp0_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= 1'b0;
      ptr       <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      rsp_data  <= '0;
      mac_rst_n <= 1'b0;
      mac_en    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mac_rst_n <= !(req0_ready || req1_ready);
          if (req0_ready || req1_ready) begin
            state <= LOAD;
            owner <= req1_ready;
            mac_a <= req1_ready ? req1_a : req0_a;
            mac_b <= req1_ready ? req1_b : req0_b;
`ifdef MAC_ARB_FIXED_PRIO_EN
            ptr   <= 1'b0;
`else
            ptr   <= !req1_ready;
`endif
          end
        end
        LOAD: begin
          state     <= RUN;
          cnt       <= '0;
          mac_rst_n <= 1'b1;
          mac_en    <= 1'b1;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            rsp_data <= mac_out;
            state    <= DONE;
            mac_en   <= 1'b0;
          end
        end
        DONE: state <= rsp_hs ? IDLE : DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mac_arbiter.md
# mac_arbiter

Controller that shares one 512-bit multiply-accumulate datapath between two requesters. It arbitrates operand requests and sequences the MAC through clear/load, a fixed-length run, and result capture. It then returns the 2W-bit product to the owning requester over a valid/ready response channel. It sits between the client logic and the MAC core, and is the only block that drives the MAC's enable and reset pins.

## Interface
- W, 256, operand width; result width is 2W.
- LATENCY, 133, number of mac_en cycles from the first run cycle until mac_out holds the product; must match the attached MAC core, minimum 2.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset: synchronous, active-high; one clock.
- req0_valid / req1_valid  in  1  requester operand valid.
- req0_ready / req1_ready  out  1  request accepted when valid&ready.
- req0_a, req0_b / req1_a, req1_b  in  W  operands.
- rsp0_valid / rsp1_valid  out  1  product available for that requester.
- rsp0_ready / rsp1_ready  in  1  requester consumes the product.
- rsp_data  out  2W  product, shared by both response channels; qualified by rspN_valid.
- mac_a, mac_b  out  W  operands to the MAC.
- mac_rst_n  out  1  MAC clear/load, active-low.
- mac_en  out  1  MAC run enable.
- mac_out  in  2W  MAC accumulator output.
- busy  out  1  high in any state other than IDLE.
- owner  out  1  index of the current or last granted requester.

## Operation
- FSM states:
  - IDLE: reqN_ready is asserted only for the requester selected by arbitration, and only in IDLE. On valid&ready, latch the operands into mac_a/mac_b, latch owner, and go to LOAD.
  - LOAD (one cycle): mac_rst_n=0, mac_en=0. This clears the MAC accumulator and loads the operands. Next state is RUN with cnt=0.
  - RUN: mac_rst_n=1, mac_en=1, cnt increments each cycle.
    - When cnt==LATENCY-1: capture mac_out into rsp_data and go to DONE.
  - DONE: mac_en=0, and rspOWNER_valid=1 until rspOWNER_ready. In the handshake cycle, go to IDLE.
    - The non-owner's rsp_valid stays 0.
- Arbitration is round-robin. A round-robin pointer starts at 0 and selects which requester wins when both are valid. The pointer flips to the non-winner after every grant. When only one requester is valid, it wins regardless of the pointer.
- mac_a/mac_b hold the last latched operands outside LOAD/RUN and are never updated while busy.
- rsp_data holds its value until the next capture.
- The cnt width is clog2(LATENCY). There is no wrap, because the FSM leaves RUN at LATENCY-1.
- The result is exactly mac_out at the capture edge; no arithmetic is performed here.

## Timing
- Reset values:
  - state IDLE, cnt 0, owner 0, pointer 0, busy 0.
  - req*_ready 0 during the reset cycle.
  - rsp*_valid 0, mac_en 0, mac_rst_n 0 (MAC held cleared while rst=1).
  - mac_a, mac_b, rsp_data all 0.
- Cycle numbering, with the request accepted at edge N:
  - LOAD in cycle N+1.
  - RUN in cycles N+2 .. N+1+LATENCY.
  - rsp_valid from cycle N+2+LATENCY.
- Request-to-response latency is LATENCY+2 cycles. The earliest next acceptance is the cycle after the response handshake (throughput is one job per LATENCY+3 cycles with rsp_ready held high).
- req_ready is combinational from state, reqN_valid and the pointer. It never depends on rsp_ready.
- A request arriving while busy waits; its valid must stay asserted and the operands must stay stable.
- A new request in the same cycle as the DONE handshake is not accepted until the following IDLE cycle.
- rst asserted in any state returns to IDLE on the next edge. An in-flight job is dropped with no response, and mac_rst_n=0 clears the MAC.
- rsp_ready held low stalls indefinitely in DONE. mac_en=0, so the MAC does not advance.

## Configuration
- MAC_ARB_FIXED_PRIO_EN defined: requester 0 always wins simultaneous requests; the pointer is unused and remains 0.
- MAC_ARB_FIXED_PRIO_EN undefined (default): round-robin as described under Operation.

## Test plan
- Single job: req0 with a=3, b=5 and LATENCY=133, with the MAC model returning a*b at run cycle 133.
  - Expect rsp0_valid at N+135 and rsp_data=15.
  - Expect mac_rst_n low exactly one cycle, at N+1, and mac_en high exactly 133 cycles.
- Contention: req0 and req1 both valid in the same IDLE cycle, with both held high for 4 jobs.
  - Default build: grants alternate 0,1,0,1.
  - With MAC_ARB_FIXED_PRIO_EN: all grants go to 0 while req0 is held.
- Backpressure: rsp1_ready held low for 20 cycles after rsp1_valid rises, using a=2^255 and b=2.
  - Expect rsp_data=2^256 stable, mac_en=0 and busy=1 throughout.
  - Expect exactly one handshake, and IDLE on the next cycle.
- Mid-run reset: rst pulsed at run cycle 40 of a req0 job.
  - Expect IDLE, busy=0 and mac_rst_n=0 in the next cycle.
  - Expect no rsp0_valid; a new request (a=7, b=9) then returns 63.
- Busy blocking: req1 asserted during req0's RUN.
  - Expect req1_ready=0 until the cycle after req0's response handshake.
  - Expect req1's operands not to appear on mac_a/mac_b before its LOAD.
